// File: rtl/fir_pkg.sv
// Shared FIR definitions: coefficient type, tap-ID sizing and the no-op command ID.
package fir_pkg;

    localparam int unsigned COEF_WIDTH = 16;
    localparam int unsigned FIR_NOP_ID = 0;

    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN
    } ldr_state_t;

    // Tap IDs 1..N must fit, so N is never a power of two and $clog2(N) suffices.
    function automatic int unsigned tap_id_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Coefficient loader: shadow bank for host writes, streamed to the FIR command
// port as one burst per commit, followed by a drain wait and a done pulse.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int unsigned INT_NUMBER_OF_TAPS = 5,
    parameter int unsigned INT_COEF_WIDTH     = 16,
    parameter int unsigned INT_DRAIN_CYCLES   = INT_NUMBER_OF_TAPS + 1
) (
    input  logic                                         clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_wr_valid,
    output logic                                         o_wr_ready,
    input  logic [tap_id_width(INT_NUMBER_OF_TAPS)-1:0]  i_wr_addr,
    input  logic signed [INT_COEF_WIDTH-1:0]             i_wr_data,
    input  logic                                         i_commit,
    output logic                                         o_busy,
    output logic                                         o_done,
    output logic                                         o_err,
    output logic                                         o_cmd_valid,
    output logic [tap_id_width(INT_NUMBER_OF_TAPS)-1:0]  o_cmd,
    output logic signed [INT_COEF_WIDTH-1:0]             o_cmd_data
);

    localparam int unsigned AW = tap_id_width(INT_NUMBER_OF_TAPS);
    localparam int unsigned DW = (INT_DRAIN_CYCLES > 1) ? $clog2(INT_DRAIN_CYCLES) : 1;
    localparam int unsigned W  = INT_COEF_WIDTH;

    localparam logic [AW-1:0] N_ID   = AW'(INT_NUMBER_OF_TAPS);
    localparam logic [AW-1:0] N_LAST = AW'(INT_NUMBER_OF_TAPS - 1);
    localparam logic [AW-1:0] NOP_ID = AW'(FIR_NOP_ID);
    localparam logic [DW-1:0] D_LAST = DW'(INT_DRAIN_CYCLES - 1);

    generate
        if ((INT_NUMBER_OF_TAPS < 3) ||
            ((INT_NUMBER_OF_TAPS & (INT_NUMBER_OF_TAPS - 1)) == 0)) begin : g_bad_taps
            $error("fir_coeff_loader: INT_NUMBER_OF_TAPS must be >= 3 and not a power of two");
        end
        if (INT_DRAIN_CYCLES < 1) begin : g_bad_drain
            $error("fir_coeff_loader: INT_DRAIN_CYCLES must be >= 1");
        end
    endgenerate

    logic signed [W-1:0] shadow [INT_NUMBER_OF_TAPS];

    ldr_state_t          state, state_n;
    logic [AW-1:0]       k, k_n, k_inc;
    logic [DW-1:0]       d, d_n;
    logic                pending, pending_n;
    logic                cmd_valid_n, busy_n, done_n, err_n;
    logic [AW-1:0]       cmd_n;
    logic signed [W-1:0] cmd_data_n;
    logic                wr_acc, wr_in_range;
    logic signed [W-1:0] tap0_fwd;

    assign o_wr_ready  = (state != ST_LOAD);
    assign wr_acc      = i_wr_valid & o_wr_ready;
    assign wr_in_range = (i_wr_addr < N_ID);
    assign k_inc       = k + 1'b1;

    // The first tap is registered on the commit edge itself, so a write to
    // tap 0 in that same cycle must bypass the shadow bank.
    assign tap0_fwd = (wr_acc && wr_in_range && (i_wr_addr == '0)) ? i_wr_data : shadow[0];

    // Shadow bank: accepted in-range host writes.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < INT_NUMBER_OF_TAPS; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_acc && wr_in_range) begin
            shadow[i_wr_addr] <= i_wr_data;
        end
    end

    // Next state, counters, pending flag and next registered outputs.
    always_comb begin
        state_n     = state;
        k_n         = k;
        d_n         = d;
        pending_n   = pending;
        cmd_valid_n = 1'b0;
        cmd_n       = NOP_ID;
        cmd_data_n  = '0;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        err_n       = o_err;

        case (state)
            ST_IDLE: begin
                // A pending commit is consumed here, in the done cycle.
                if (i_commit || pending) begin
                    state_n     = ST_LOAD;
                    k_n         = '0;
                    pending_n   = 1'b0;
                    err_n       = 1'b0;
                    cmd_valid_n = 1'b1;
                    cmd_n       = AW'(1);
                    cmd_data_n  = tap0_fwd;
                    busy_n      = 1'b1;
                end
            end
            ST_LOAD: begin
                busy_n = 1'b1;
                if (i_commit) pending_n = 1'b1;
                if (k == N_LAST) begin
                    state_n = ST_DRAIN;
                    d_n     = '0;
                end else begin
                    k_n         = k_inc;
                    cmd_valid_n = 1'b1;
                    cmd_n       = k_inc + 1'b1;
                    cmd_data_n  = shadow[k_inc];
                end
            end
            ST_DRAIN: begin
                if (i_commit) pending_n = 1'b1;
                if (d == D_LAST) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    d_n    = d + 1'b1;
                    busy_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A bad address in the commit cycle belongs to the new burst.
        if (wr_acc && !wr_in_range) err_n = 1'b1;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            k           <= '0;
            d           <= '0;
            pending     <= 1'b0;
            o_cmd_valid <= 1'b0;
            o_cmd       <= NOP_ID;
            o_cmd_data  <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_n;
            k           <= k_n;
            d           <= d_n;
            pending     <= pending_n;
            o_cmd_valid <= cmd_valid_n;
            o_cmd       <= cmd_n;
            o_cmd_data  <= cmd_data_n;
            o_busy      <= busy_n;
            o_done      <= done_n;
            o_err       <= err_n;
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: per-cycle window model plus directed literals.
module tb_fir_coeff_loader;

    localparam int N  = 5;
    localparam int W  = 16;
    localparam int D  = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_wr_valid = 1'b0;
    logic          o_wr_ready;
    logic [AW-1:0] i_wr_addr = '0;
    logic [W-1:0]  i_wr_data = '0;
    logic          i_commit = 1'b0;
    logic          o_busy, o_done, o_err, o_cmd_valid;
    logic [AW-1:0] o_cmd;
    logic [W-1:0]  o_cmd_data;

    fir_coeff_loader #(
        .INT_NUMBER_OF_TAPS(N),
        .INT_COEF_WIDTH    (W),
        .INT_DRAIN_CYCLES  (D)
    ) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_wr_valid (i_wr_valid),
        .o_wr_ready (o_wr_ready),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_commit   (i_commit),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_cmd_valid(o_cmd_valid),
        .o_cmd      (o_cmd),
        .o_cmd_data (o_cmd_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a burst launched at edge s owns cycles s..s+N-1 (LOAD),
    // s+N..s+N+D-1 (DRAIN) and pulses done in cycle s+N+D.
    int          e = 0;
    bit          act = 0;
    int          s = 0;
    bit          pend = 0;
    bit          merr = 0;
    logic [W-1:0] msh [N];
    logic [W-1:0] snap [N];
    bit          x_valid, x_busy, x_done, x_err, x_ready;
    int          x_cmd;
    logic [W-1:0] x_data;

    always @(posedge clk) begin
        if (!rst_n) begin
            e = 0; act = 0; pend = 0; merr = 0;
            for (int i = 0; i < N; i++) begin msh[i] = '0; snap[i] = '0; end
            x_valid = 0; x_busy = 0; x_done = 0; x_err = 0; x_ready = 1; x_cmd = 0; x_data = '0;
        end else begin
            int  p;
            bit  load_p, busy_p, bad;
            e++;
            p      = e - 1;
            load_p = act && (p >= s) && (p <= s + N - 1);
            busy_p = act && (p >= s) && (p <= s + N + D - 1);
            bad    = 0;
            if (i_wr_valid && !load_p) begin
                if (int'(i_wr_addr) < N) msh[i_wr_addr] = i_wr_data;
                else bad = 1;
            end
            if (!busy_p && (i_commit || pend)) begin
                act = 1; s = e; pend = 0; merr = 0;
                for (int i = 0; i < N; i++) snap[i] = msh[i];
            end else if (busy_p && i_commit) begin
                pend = 1;
            end
            if (bad) merr = 1;
            x_valid = act && (e >= s) && (e <= s + N - 1);
            x_cmd   = x_valid ? (e - s + 1) : 0;
            x_data  = x_valid ? snap[e - s] : '0;
            x_busy  = act && (e >= s) && (e <= s + N + D - 1);
            x_done  = act && (e == s + N + D);
            x_err   = merr;
            x_ready = !x_valid;
        end
    end

    logic [W-1:0]  cap_data[$];
    logic [AW-1:0] cap_id[$];
    int            done_cnt = 0;

    // Compare every cycle against the model (or reset values while in reset).
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", 32'(o_cmd_valid), 0);
            chk("rst_busy",  32'(o_busy), 0);
            chk("rst_ready", 32'(o_wr_ready), 1);
        end else begin
            chk("cmd_valid", 32'(o_cmd_valid), 32'(x_valid));
            chk("cmd_id",    32'(o_cmd), 32'(x_cmd));
            chk("cmd_data",  32'(o_cmd_data), 32'(x_data));
            chk("busy",      32'(o_busy), 32'(x_busy));
            chk("done",      32'(o_done), 32'(x_done));
            chk("err",       32'(o_err), 32'(x_err));
            chk("wr_ready",  32'(o_wr_ready), 32'(x_ready));
            if (o_cmd_valid) begin
                cap_data.push_back(o_cmd_data);
                cap_id.push_back(o_cmd);
            end
            if (o_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] dat, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        i_wr_valid = 1; i_wr_addr = a; i_wr_data = dat;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = o_wr_ready;
            if (!ok) waited++;
            tick();
        end
        i_wr_valid = 0;
        if (!ok) chk("wr_timeout", 0, 1);
    endtask

    task automatic do_commit();
        i_commit = 1; tick(); i_commit = 0;
    endtask

    // Returns cycles from the commit cycle (count 1 = first LOAD cycle follows it).
    task automatic wait_done(output int cyc);
        bit seen;
        seen = 0;
        cyc = 0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk);
            if (o_done) begin seen = 1; cyc = c; end
        end
        if (!seen) chk("done_timeout", 0, 1);
        tick();
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_id.delete();
    endtask

    task automatic chk_burst(input string nm, input logic [W-1:0] exp [N]);
        chk({nm, "_len"}, 32'(cap_data.size()), N);
        for (int i = 0; i < N && i < cap_data.size(); i++) begin
            chk({nm, "_data"}, 32'(cap_data[i]), 32'(exp[i]));
            chk({nm, "_id"},   32'(cap_id[i]),   32'(i + 1));
        end
    endtask

    initial begin
        int lat, w, d0;
        logic [W-1:0] zeros [N] = '{default: '0};
        logic [W-1:0] basic [N] = '{16'h0100, 16'hFF00, 16'h7FFF, 16'h8000, 16'h0001};
        logic [W-1:0] after [N] = '{16'h1234, 16'h5555, 16'h7FFF, 16'h8000, 16'h0001};

        // Reset
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("init_valid", 32'(o_cmd_valid), 0);
        chk("init_cmd",   32'(o_cmd), 0);
        chk("init_data",  32'(o_cmd_data), 0);
        chk("init_busy",  32'(o_busy), 0);
        chk("init_done",  32'(o_done), 0);
        chk("init_err",   32'(o_err), 0);
        chk("init_ready", 32'(o_wr_ready), 1);
        tick();

        // Commit with no writes
        clear_cap();
        do_commit();
        wait_done(lat);
        chk("latency_empty", 32'(lat), 12);
        chk_burst("empty", zeros);

        // Basic load
        for (int i = 0; i < N; i++) do_write(AW'(i), basic[i], w);
        clear_cap();
        do_commit();
        wait_done(lat);
        chk("latency_basic", 32'(lat), 12);
        chk_burst("basic", basic);

        // Write forwarded in the commit cycle
        clear_cap();
        i_wr_valid = 1; i_wr_addr = 0; i_wr_data = 16'h1234; i_commit = 1;
        tick();
        i_wr_valid = 0; i_commit = 0;
        wait_done(lat);
        chk("fwd_tap0", cap_data.size() > 0 ? 32'(cap_data[0]) : 32'hDEAD, 32'h1234);
        chk("fwd_tap2", cap_data.size() > 2 ? 32'(cap_data[2]) : 32'hDEAD, 32'h7FFF);

        // Write blocked during LOAD, accepted in DRAIN
        do_commit();
        tick(); tick();
        do_write(1, 16'h5555, w);
        chk("wr_block_wait", 32'(w), 3);
        wait_done(lat);
        clear_cap();
        do_commit();
        wait_done(lat);
        chk_burst("after_block", after);

        // Pending commits: one in LOAD, one in DRAIN
        clear_cap();
        d0 = done_cnt;
        do_commit();
        tick(); tick();
        do_commit();
        tick(); tick(); tick();
        do_commit();
        wait_done(lat);
        @(negedge clk);
        chk("relaunch_busy",  32'(o_busy), 1);
        chk("relaunch_valid", 32'(o_cmd_valid), 1);
        chk("relaunch_id",    32'(o_cmd), 1);
        tick();
        wait_done(lat);
        repeat (20) tick();
        chk("pending_dones",  32'(done_cnt - d0), 2);
        chk("pending_cmds",   32'(cap_data.size()), 2 * N);

        // Out-of-range write: sticky error, shadow untouched
        do_write(6, 16'h7777, w);
        @(negedge clk);
        chk("err_set", 32'(o_err), 1);
        tick(); tick(); tick();
        chk("err_sticky", 32'(o_err), 1);
        clear_cap();
        do_commit();
        @(negedge clk);
        chk("err_cleared", 32'(o_err), 0);
        wait_done(lat);
        chk_burst("err_burst", after);

        // Reset during the third LOAD cycle
        do_commit();
        tick(); tick();
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'(o_cmd_valid), 0);
        chk("mid_rst_busy",  32'(o_busy), 0);
        chk("mid_rst_cmd",   32'(o_cmd), 0);
        chk("mid_rst_ready", 32'(o_wr_ready), 1);
        @(posedge clk);
        #2 rst_n = 1;
        tick();
        d0 = done_cnt;
        repeat (20) tick();
        chk("no_relaunch", 32'(done_cnt - d0), 0);
        clear_cap();
        do_commit();
        wait_done(lat);
        chk("latency_post_rst", 32'(lat), 12);
        chk_burst("post_rst", zeros);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
